// File: rtl/layer_mem_responder_if.sv
// Bus between the master control center and the layer-result memory responder.
// Optional feature macro: LMEM_ERR_FLAG_EN (adds the access_err status signal).
interface layer_mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20
);
  logic [2:0]        csel;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              crd_valid;
  logic              mem_ready;
`ifdef LMEM_ERR_FLAG_EN
  logic [1:0]        access_err;
`endif

  modport master (
    output csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
`ifdef LMEM_ERR_FLAG_EN
    input  access_err,
`endif
    input  cdata_rd, crd_valid, mem_ready
  );

  modport slave (
    input  csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
`ifdef LMEM_ERR_FLAG_EN
    output access_err,
`endif
    output cdata_rd, crd_valid, mem_ready
  );
endinterface

// File: rtl/layer_mem_responder.sv
// Memory-side responder for the CNN layer-result bus.
// NBANK result banks selected by csel 1..NBANK; after reset every bank is
// zeroed one address per cycle before any access is accepted.
// Optional feature macro: LMEM_ERR_FLAG_EN (sticky access_err[1:0] flags).
module layer_mem_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4096,
  parameter int NBANK  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  layer_mem_responder_if.slave  bus
);

  localparam int AI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [AI_W-1:0]   r_clr_addr;
  logic [DATA_W-1:0] r_mem [NBANK][DEPTH];
  logic [DATA_W-1:0] r_cdata_rd;
  logic              r_crd_valid;

  logic              w_csel_ok;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [BK_W-1:0]   w_bank;
  logic [AI_W-1:0]   w_wr_idx;
  logic [AI_W-1:0]   w_rd_idx;
  logic              w_clr_last;

  // Decode bank select and address legality shared by both strobes.
  always_comb begin
    w_csel_ok     = (bus.csel != 3'd0) && (bus.csel <= 3'(NBANK));
    w_wr_in_range = ({1'b0, bus.caddr_wr} < (ADDR_W+1)'(DEPTH));
    w_rd_in_range = ({1'b0, bus.caddr_rd} < (ADDR_W+1)'(DEPTH));
    w_wr_ok       = w_csel_ok && w_wr_in_range;
    w_rd_ok       = w_csel_ok && w_rd_in_range;
    w_bank        = BK_W'(bus.csel - 3'd1);
    w_wr_idx      = bus.caddr_wr[AI_W-1:0];
    w_rd_idx      = bus.caddr_rd[AI_W-1:0];
    w_clr_last    = (r_clr_addr == AI_W'(DEPTH - 1));
  end

  // State register; any reset restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave CLEAR after the last address has been zeroed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLEAR:   if (w_clr_last) w_next_state = READY;
      READY:   w_next_state = READY;
      default: w_next_state = CLEAR;
    endcase
  end

  // Clear address counter, advancing once per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + AI_W'(1);
    end
  end

  // Bank storage: parallel zeroing during CLEAR, bus writes in READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        for (int unsigned b = 0; b < NBANK; b++) begin
          r_mem[b][r_clr_addr] <= '0;
        end
      end else if (bus.cwr && w_wr_ok) begin
        r_mem[w_bank][w_wr_idx] <= bus.cdata_wr;
      end
    end
  end

  // Registered read port; reads see the pre-write word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cdata_rd  <= '0;
      r_crd_valid <= 1'b0;
    end else if ((r_state == READY) && bus.crd) begin
      r_crd_valid <= 1'b1;
      r_cdata_rd  <= w_rd_ok ? r_mem[w_bank][w_rd_idx] : '0;
    end else begin
      r_crd_valid <= 1'b0;
    end
  end

`ifdef LMEM_ERR_FLAG_EN
  logic [1:0] r_access_err;

  // Sticky flags: bit0 illegal access in READY, bit1 any access during CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_access_err <= '0;
    end else begin
      if ((r_state == READY) &&
          ((bus.cwr && !w_wr_ok) || (bus.crd && !w_rd_ok))) begin
        r_access_err[0] <= 1'b1;
      end
      if ((r_state == CLEAR) && (bus.cwr || bus.crd)) begin
        r_access_err[1] <= 1'b1;
      end
    end
  end

  assign bus.access_err = r_access_err;
`endif

  assign bus.cdata_rd  = r_cdata_rd;
  assign bus.crd_valid = r_crd_valid;
  assign bus.mem_ready = (r_state == READY);

endmodule
